// File: rtl/wb_cfg_bridge_pkg.sv
// wb_cfg_bridge_pkg: register offsets, FSM state encoding and default ID for wb_cfg_bridge
package wb_cfg_bridge_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ACK  = 2'd2
   } state_t;
   localparam logic [7:0]  OFF_PROG    = 8'h00;
   localparam logic [7:0]  OFF_DIR     = 8'h04;
   localparam logic [7:0]  OFF_PIN_DIR = 8'h08;
   localparam logic [7:0]  OFF_PIN_IN  = 8'h0C;
   localparam logic [7:0]  OFF_WCOUNT  = 8'h10;
   localparam logic [7:0]  OFF_ID      = 8'h14;
   localparam logic [31:0] ID_DEFAULT  = 32'h7472_0001;
endpackage

// File: rtl/wb_cfg_bridge_byte_lane_merge.sv
// wb_cfg_bridge_byte_lane_merge: byte-lane merge, merged = (old_val & ~mask) | (new_val & mask)
//   sel      in  IO_PINS/8  byte-lane enables, lane i covers bits [8i+7:8i]
//   old_val  in  IO_PINS    current shadow value
//   new_val  in  IO_PINS    incoming write data
//   merged   out IO_PINS    merged value
//   any      out 1          at least one lane enabled
module wb_cfg_bridge_byte_lane_merge #(
   parameter int IO_PINS = 16
) (
   input  logic [IO_PINS/8-1:0] sel,
   input  logic [IO_PINS-1:0]   old_val,
   input  logic [IO_PINS-1:0]   new_val,
   output logic [IO_PINS-1:0]   merged,
   output logic                 any
);
   logic [IO_PINS-1:0] mask;
   for (genvar i = 0; i < IO_PINS/8; i++) begin : g_lane
      assign mask[i*8 +: 8] = {8{sel[i]}};
   end
   assign merged = (old_val & ~mask) | (new_val & mask);
   assign any    = |sel;
endmodule

// File: rtl/wb_cfg_bridge.sv
// wb_cfg_bridge: Wishbone classic slave driving the io_pads config write port with readable shadows
//   clk, rst_hard_n             clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i        wishbone cycle, strobe, write enable
//   wbs_sel_i/adr_i/dat_i       byte lanes, byte address, write data
//   wbs_ack_o/dat_o             one-cycle acknowledge, registered read data
//   cfg_we/cfg_addr/cfg_wdata   io_pads config write (addr 0=programming, 1=saved_dir)
//   pin_dir, pin_data_in        live pin status from io_pads
module wb_cfg_bridge
   import wb_cfg_bridge_pkg::*;
#(
   parameter int          IO_PINS   = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          WIN_BITS  = 5,
   parameter logic [31:0] ID_VALUE  = ID_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_hard_n,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   output logic               cfg_we,
   output logic               cfg_addr,
   output logic [IO_PINS-1:0] cfg_wdata,
   input  logic [IO_PINS-1:0] pin_dir,
   input  logic [IO_PINS-1:0] pin_data_in
);
   state_t               state, state_nx;
   logic [7:0]           req_off;
   logic                 req_we;
   logic [IO_PINS/8-1:0] req_sel;
   logic [IO_PINS-1:0]   req_dat;
   logic                 prog_sh;
   logic [IO_PINS-1:0]   dir_sh;
   logic [7:0]           wcount;
   logic [IO_PINS-1:0]   old_val, merged;
   logic                 lane_any, hit, start, wr_reg, done;
   logic [31:0]          rd_mux;
   logic                 unused_ok;
   // Lanes above IO_PINS and address bits inside a word are intentionally ignored.
   assign unused_ok = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i};
   assign hit     = wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS];
   assign start   = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
   assign old_val = req_off[2] ? dir_sh : IO_PINS'(prog_sh);
   wb_cfg_bridge_byte_lane_merge #(.IO_PINS(IO_PINS)) u_merge (
      .sel     (req_sel),
      .old_val (old_val),
      .new_val (req_dat),
      .merged  (merged),
      .any     (lane_any)
   );
   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = start ? EXEC : IDLE;
         EXEC:    state_nx = wbs_cyc_i ? ACK : IDLE;
         default: state_nx = IDLE;
      endcase
      // done: EXEC with the master still present, i.e. the transfer will be acked
      done      = state == EXEC && wbs_cyc_i;
      wr_reg    = req_we && (req_off == OFF_PROG || req_off == OFF_DIR) && lane_any;
      cfg_we    = done && wr_reg;
      cfg_addr  = cfg_we && req_off[2];
      cfg_wdata = cfg_we ? merged : '0;
      rd_mux    = req_off == OFF_PROG    ? {31'd0, prog_sh} :
                  req_off == OFF_DIR     ? 32'(dir_sh) :
                  req_off == OFF_PIN_DIR ? 32'(pin_dir) :
                  req_off == OFF_PIN_IN  ? 32'(pin_data_in) :
                  req_off == OFF_WCOUNT  ? 32'(wcount) :
                  req_off == OFF_ID      ? ID_VALUE : 32'd0;
   end
   always_ff @(posedge clk or negedge rst_hard_n) begin
      if (!rst_hard_n) begin
         state     <= IDLE;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         req_off   <= '0;
         req_we    <= 1'b0;
         req_sel   <= '0;
         req_dat   <= '0;
         prog_sh   <= 1'b0;
         dir_sh    <= '0;
         wcount    <= '0;
      end else begin
         state     <= state_nx;
         wbs_ack_o <= done;
         wbs_dat_o <= (done && !req_we) ? rd_mux : '0;
         if (state == IDLE && start) begin
            req_off <= 8'(wbs_adr_i[WIN_BITS-1:0]);
            req_we  <= wbs_we_i;
            req_sel <= wbs_sel_i[IO_PINS/8-1:0];
            req_dat <= wbs_dat_i[IO_PINS-1:0];
         end
         if (cfg_we) begin
            if (req_off[2]) dir_sh <= merged;
            else prog_sh <= merged[0];
            wcount <= wcount + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_wb_cfg_bridge.sv
// tb_wb_cfg_bridge: directed self-checking bench for wb_cfg_bridge
module tb_wb_cfg_bridge;
   localparam logic [31:0] BASE = 32'h3000_0000;
   logic        clk = 1'b0;
   logic        rst_hard_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'h0, dat = 32'h0;
   logic        ack;
   logic [31:0] dat_o;
   logic        cfg_we, cfg_addr;
   logic [15:0] cfg_wdata;
   logic [15:0] pin_dir = 16'h0, pin_data_in = 16'h0;
   int          compared = 0, mismatched = 0;
   logic        a_ack, a_waddr;
   int          a_lat, a_wes, acks;
   logic [31:0] a_rd;
   logic [15:0] a_wdata;

   wb_cfg_bridge #(
      .IO_PINS(16), .BASE_ADDR(BASE), .WIN_BITS(5), .ID_VALUE(32'h7472_0001)
   ) dut (
      .clk(clk), .rst_hard_n(rst_hard_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .pin_dir(pin_dir), .pin_data_in(pin_data_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task xfer(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
      a_ack = 1'b0; a_lat = 0; a_wes = 0; a_rd = 32'h0; a_waddr = 1'b0; a_wdata = 16'h0;
      for (int n = 1; n <= 10 && !a_ack; n++) begin
         @(posedge clk); #1;
         if (cfg_we) begin
            a_wes++; a_waddr = cfg_addr; a_wdata = cfg_wdata;
         end
         if (ack) begin
            a_ack = 1'b1; a_lat = n; a_rd = dat_o;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task pulse_reset();
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; rst_hard_n = 1'b0;
      @(posedge clk); #1;
      rst_hard_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_cfg_we", 32'(cfg_we), 32'd0);
      chk("rst_cfg_addr", 32'(cfg_addr), 32'd0);
      chk("rst_cfg_wdata", 32'(cfg_wdata), 32'd0);
      rst_hard_n = 1'b1;
      // full write to DIR
      xfer(BASE + 32'h04, 1'b1, 4'hF, 32'h0000_A5C3);
      chk("dir_w1_ack", 32'(a_ack), 32'd1);
      chk("dir_w1_lat", 32'(a_lat), 32'd2);
      chk("dir_w1_wes", 32'(a_wes), 32'd1);
      chk("dir_w1_addr", 32'(a_waddr), 32'd1);
      chk("dir_w1_wdata", 32'(a_wdata), 32'h0000_A5C3);
      xfer(BASE + 32'h04, 1'b0, 4'hF, 32'h0);
      chk("dir_r1", a_rd, 32'h0000_A5C3);
      chk("dir_r1_wes", 32'(a_wes), 32'd0);
      // partial write, upper lane only
      xfer(BASE + 32'h04, 1'b1, 4'h2, 32'h0000_FF00);
      chk("dir_w2_wdata", 32'(a_wdata), 32'h0000_FFC3);
      chk("dir_w2_wes", 32'(a_wes), 32'd1);
      xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
      chk("wcount_2", a_rd, 32'd2);
      // PROG write and live pin reads
      xfer(BASE + 32'h00, 1'b1, 4'hF, 32'h0000_0001);
      chk("prog_w_addr", 32'(a_waddr), 32'd0);
      chk("prog_w_wdata", 32'(a_wdata), 32'h0000_0001);
      chk("prog_w_wes", 32'(a_wes), 32'd1);
      pin_data_in = 16'h1234;
      pin_dir = 16'h5A0F;
      xfer(BASE + 32'h0C, 1'b0, 4'hF, 32'h0);
      chk("pin_in_rd", a_rd, 32'h0000_1234);
      chk("pin_in_wes", 32'(a_wes), 32'd0);
      xfer(BASE + 32'h08, 1'b0, 4'hF, 32'h0);
      chk("pin_dir_rd", a_rd, 32'h0000_5A0F);
      xfer(BASE + 32'h00, 1'b0, 4'hF, 32'h0);
      chk("prog_rd", a_rd, 32'h0000_0001);
      xfer(BASE + 32'h14, 1'b0, 4'hF, 32'h0);
      chk("id_rd", a_rd, 32'h7472_0001);
      // off-window access must never be acked
      xfer(BASE + 32'h40, 1'b0, 4'hF, 32'h0);
      chk("offwin_ack", 32'(a_ack), 32'd0);
      xfer(BASE + 32'h18, 1'b0, 4'hF, 32'h0);
      chk("unmapped_ack", 32'(a_ack), 32'd1);
      chk("unmapped_rd", a_rd, 32'd0);
      // write to RO offset and write with no lanes: acked, no config write
      xfer(BASE + 32'h08, 1'b1, 4'hF, 32'hFFFF_FFFF);
      chk("ro_w_ack", 32'(a_ack), 32'd1);
      chk("ro_w_wes", 32'(a_wes), 32'd0);
      xfer(BASE + 32'h04, 1'b1, 4'h0, 32'h0000_1111);
      chk("sel0_ack", 32'(a_ack), 32'd1);
      chk("sel0_wes", 32'(a_wes), 32'd0);
      // abort: cyc dropped while in EXEC
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h04; dat = 32'h0000_1111;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      #1;
      chk("abort_cfg_we", 32'(cfg_we), 32'd0);
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ack || cfg_we) acks++;
      end
      chk("abort_no_ack", 32'(acks), 32'd0);
      xfer(BASE + 32'h04, 1'b0, 4'hF, 32'h0);
      chk("abort_dir", a_rd, 32'h0000_FFC3);
      xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
      chk("abort_wcount", a_rd, 32'd3);
      // counter wrap
      pulse_reset();
      for (int i = 0; i < 256; i++) xfer(BASE + 32'h00, 1'b1, 4'h1, 32'(i & 1));
      xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
      chk("wcount_wrap", a_rd, 32'd0);
      xfer(BASE + 32'h00, 1'b0, 4'hF, 32'h0);
      chk("prog_after_loop", a_rd, 32'd1);
      // reset asserted while ack is high
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h14;
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_ack", 32'(ack), 32'd1);
      rst_hard_n = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(ack), 32'd0);
      chk("mid_rst_dat", dat_o, 32'd0);
      chk("mid_rst_cfg_we", 32'(cfg_we), 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      rst_hard_n = 1'b1;
      xfer(BASE + 32'h00, 1'b0, 4'hF, 32'h0);
      chk("post_rst_prog", a_rd, 32'd0);
      xfer(BASE + 32'h04, 1'b0, 4'hF, 32'h0);
      chk("post_rst_dir", a_rd, 32'd0);
      xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
      chk("post_rst_wcount", a_rd, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
